mem_port_arbiter: RTL and testbench

Sequences and shares the single external memory bus between the instruction-fetch stage and the memory-access stage of the Beta pipeline. Accepts one request per requester and runs it as a variable-latency req/ack bus transaction. Returns read data with a one-cycle valid pulse and generates the per-stage stall signals. Data accesses take priority, with a bounded-starvation guarantee for fetch.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single external memory bus between the
// instruction-fetch stage and the memory-access stage of the Beta pipeline.
// Data accesses win arbitration, but after MAX_MEM_GRANTS consecutive data
// grants with a fetch waiting, the fetch is served next.
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the bus-ack watchdog.
module mem_port_arbiter #(
    parameter int MAX_MEM_GRANTS = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, RESP} state_t;

    localparam logic [3:0]  MEM_LIMIT  = 4'(MAX_MEM_GRANTS);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    if (MAX_MEM_GRANTS < 1 || MAX_MEM_GRANTS > 15) begin : g_bad_max_grants
        $error("mem_port_arbiter: MAX_MEM_GRANTS must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t     state;
    state_t     state_next;
    logic [3:0] mem_cnt;
    logic       served_mem;
    logic       grant_if;
    logic       grant_mem;
    logic       ack_done;
    logic       wd_expire;
    logic       in_bus;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;
`endif

    assign in_bus    = (state == BUS_IF) || (state == BUS_MEM);
    assign bus_req   = in_bus;
    assign if_valid  = (state == RESP) && !served_mem;
    assign mem_valid = (state == RESP) && served_mem;
    assign if_stall  = if_req && !if_valid;
    assign mem_stall = mem_req && !mem_valid;

    // State register; reset abandons any bus transaction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, bus completion and watchdog expiry decide the next state.
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_mem  = 1'b0;
        ack_done   = 1'b0;
        wd_expire  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && (!if_req || (mem_cnt < MEM_LIMIT))) begin
                    grant_mem  = 1'b1;
                    state_next = BUS_MEM;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = BUS_IF;
                end
            end
            BUS_IF, BUS_MEM: begin
                if (bus_ack) begin
                    ack_done   = 1'b1;
                    state_next = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wd_cnt == WD_LIMIT) begin
                    wd_expire  = 1'b1;
                    state_next = RESP;
                end
`endif
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the granted requester's address and payload for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr   <= 32'd0;
            bus_we     <= 1'b0;
            bus_wdata  <= 32'd0;
            served_mem <= 1'b0;
        end else if (grant_mem) begin
            bus_addr   <= mem_addr;
            bus_we     <= mem_we;
            bus_wdata  <= mem_wdata;
            served_mem <= 1'b1;
        end else if (grant_if) begin
            bus_addr   <= if_addr;
            bus_we     <= 1'b0;
            bus_wdata  <= 32'd0;
            served_mem <= 1'b0;
        end
    end

    // Count data grants made while a fetch is waiting, to bound fetch starvation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt <= 4'd0;
        end else if (grant_if) begin
            mem_cnt <= 4'd0;
        end else if (grant_mem) begin
            mem_cnt <= if_req ? (mem_cnt + 4'd1) : 4'd0;
        end
    end

    // Capture returned data; stores never touch mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata  <= 32'd0;
            mem_rdata <= 32'd0;
        end else if (ack_done) begin
            if (!served_mem) begin
                if_rdata <= bus_rdata;
            end else if (!bus_we) begin
                mem_rdata <= bus_rdata;
            end
        end else if (wd_expire) begin
            if (!served_mem) begin
                if_rdata <= TIMEOUT_DATA;
            end else if (!bus_we) begin
                mem_rdata <= TIMEOUT_DATA;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: counts bus cycles without ack, restarting at every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= 8'd0;
        end else if (grant_if || grant_mem) begin
            wd_cnt <= 8'd0;
        end else if (in_bus && !bus_ack) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (wd_expire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Table-driven single transactions plus hand-written multi-cycle sequences;
// completions are checked against a scoreboard queue filled when each bus
// ack is driven.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_delay;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_mem;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[8];

    mem_port_arbiter #(
        .MAX_MEM_GRANTS(4),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .if_stall   (if_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .mem_stall  (mem_stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExpect(input logic is_mem, input logic [31:0] rdata);
        exp_t e;
        e.is_mem = is_mem;
        e.rdata  = rdata;
        sb_q.push_back(e);
    endtask

    task automatic waitBusReq(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (bus_req) ok = 1'b1;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n   = 1'b0;
        if_req  = 1'b0;
        mem_req = 1'b0;
        bus_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete transaction: request, check grant and hold, ack, check completion.
    task automatic applyStimulus(input vec_t v);
        if (v.is_mem) begin
            mem_req   = 1'b1;
            mem_we    = v.we;
            mem_addr  = v.addr;
            mem_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        @(negedge clk);
        checkOutput("grant_bus_req", bus_req, 1);
        checkOutput("grant_bus_addr", bus_addr, v.addr);
        checkOutput("grant_bus_we", bus_we, v.is_mem ? v.we : 1'b0);
        checkOutput("grant_bus_wdata", bus_wdata, v.is_mem ? v.wdata : 32'd0);
        checkOutput("wait_stall", v.is_mem ? mem_stall : if_stall, 1);
        for (int i = 2; i <= v.ack_delay; i++) begin
            @(negedge clk);
            checkOutput("hold_bus_req", bus_req, 1);
            checkOutput("hold_stall", v.is_mem ? mem_stall : if_stall, 1);
        end
        pushExpect(v.is_mem, v.exp_rdata);
        bus_ack   = 1'b1;
        bus_rdata = v.rdata;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        checkOutput("resp_bus_req", bus_req, 0);
        checkOutput("resp_valid", {31'd0, v.is_mem ? mem_valid : if_valid}, 1);
        checkOutput("resp_stall", v.is_mem ? mem_stall : if_stall, 0);
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        checkOutput("after_valid", {30'd0, if_valid, mem_valid}, 0);
        checkOutput("after_bus_req", bus_req, 0);
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("valid_exclusive", {31'd0, if_valid & mem_valid}, 0);
            if (if_valid || mem_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_unexpected_valid", {30'd0, if_valid, mem_valid}, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("sb_port", {31'd0, mem_valid}, {31'd0, mon_e.is_mem});
                    checkOutput("sb_rdata", mem_valid ? mem_rdata : if_rdata, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        bit ok;
        bit exp_mem;
        vec_t v;

        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        bus_rdata = 32'd0;
        bus_ack   = 1'b0;

        //                  is_mem we    addr           wdata          dly rdata          exp_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         3, 32'hC3E0_0004, 32'hC3E0_0004};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0080, 32'hAAAA_0000, 1, 32'h1111_2222, 32'h1111_2222};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 2, 32'hFFFF_FFFF, 32'h1111_2222};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         1, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h5555_5555, 5, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1, 32'h0BAD_0BAD, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         2, 32'h7654_3210, 32'h7654_3210};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         1, 32'h0000_0066, 32'h0000_0066};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_bus_req", bus_req, 0);
        checkOutput("reset_bus_addr", bus_addr, 0);
        checkOutput("reset_bus_we", bus_we, 0);
        checkOutput("reset_if_rdata", if_rdata, 0);
        checkOutput("reset_mem_rdata", mem_rdata, 0);
        checkOutput("reset_valids", {30'd0, if_valid, mem_valid}, 0);
        checkOutput("reset_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of single transactions
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        // Ack while idle must be ignored
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_0077;
        @(negedge clk);
        bus_ack = 1'b0;
        checkOutput("idle_ack_bus_req", bus_req, 0);
        checkOutput("idle_ack_mem_rdata", mem_rdata, 32'h0000_0066);
        @(negedge clk);
        checkOutput("idle_ack_valids", {30'd0, if_valid, mem_valid}, 0);

        // Data request arriving during a fetch waits with stall held
        if_req  = 1'b1;
        if_addr = 32'h0000_0500;
        @(negedge clk);
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0600;
        @(negedge clk);
        checkOutput("wait_bus_addr", bus_addr, 32'h0000_0500);
        checkOutput("wait_mem_stall_bus", mem_stall, 1);
        pushExpect(1'b0, 32'h55AA_55AA);
        bus_ack   = 1'b1;
        bus_rdata = 32'h55AA_55AA;
        @(negedge clk);
        bus_ack = 1'b0;
        checkOutput("wait_if_valid", if_valid, 1);
        checkOutput("wait_mem_stall_resp", mem_stall, 1);
        if_req = 1'b0;
        @(negedge clk);
        checkOutput("wait_idle_bus_req", bus_req, 0);
        checkOutput("wait_mem_stall_idle", mem_stall, 1);
        @(negedge clk);
        checkOutput("wait_mem_grant_req", bus_req, 1);
        checkOutput("wait_mem_grant_addr", bus_addr, 32'h0000_0600);
        pushExpect(1'b1, 32'h0000_6666);
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_6666;
        @(negedge clk);
        bus_ack = 1'b0;
        checkOutput("wait_mem_valid", mem_valid, 1);
        mem_req = 1'b0;
        @(negedge clk);

        // Priority and fairness: both held, immediate ack, expect MEM x4 then IF, twice
        doReset();
        if_req   = 1'b1;
        if_addr  = 32'h0000_0200;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0300;
        for (int g = 0; g < 10; g++) begin
            exp_mem = ((g % 5) != 4);
            waitBusReq(6, ok);
            checkOutput("fair_bus_req_seen", {31'd0, ok}, 1);
            if (!ok) break;
            checkOutput("fair_grant_addr", bus_addr, exp_mem ? 32'h0000_0300 : 32'h0000_0200);
            pushExpect(exp_mem, 32'hA000_0000 + 32'(g));
            bus_ack   = 1'b1;
            bus_rdata = 32'hA000_0000 + 32'(g);
            @(negedge clk);
            bus_ack = 1'b0;
            checkOutput("fair_valid", {30'd0, if_valid, mem_valid}, exp_mem ? 32'd1 : 32'd2);
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        checkOutput("fair_end_bus_req", bus_req, 0);

        // Reset in the middle of a store
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_0ABC;
        mem_wdata = 32'h1357_9BDF;
        waitBusReq(4, ok);
        checkOutput("rst_mid_bus_req_before", {31'd0, ok}, 1);
        checkOutput("rst_mid_bus_we_before", bus_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_bus_req", bus_req, 0);
        checkOutput("rst_mid_bus_we", bus_we, 0);
        checkOutput("rst_mid_bus_addr", bus_addr, 0);
        checkOutput("rst_mid_bus_wdata", bus_wdata, 0);
        checkOutput("rst_mid_mem_rdata", mem_rdata, 0);
        checkOutput("rst_mid_if_rdata", if_rdata, 0);
        checkOutput("rst_mid_valids", {30'd0, if_valid, mem_valid}, 0);
        @(negedge clk);
        mem_req = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rst_mid_no_valid", {30'd0, if_valid, mem_valid}, 0);
            checkOutput("rst_mid_no_bus_req", bus_req, 0);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog expiry on a load that never gets an ack
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0900;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checkOutput("to_bus_req_held", bus_req, 1);
        end
        pushExpect(1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("to_bus_req_dropped", bus_req, 0);
        checkOutput("to_mem_valid", mem_valid, 1);
        checkOutput("to_err_set", timeout_err, 1);
        mem_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("to_err_sticky", timeout_err, 1);
        doReset();
        @(negedge clk);
        checkOutput("to_err_cleared", timeout_err, 0);

        // Ack on the expiry cycle completes normally
        v = '{1'b1, 1'b0, 32'h0000_0A00, 32'h0, 10, 32'h0BAD_F00D, 32'h0BAD_F00D};
        applyStimulus(v);
        checkOutput("to_ack_wins_err", timeout_err, 0);
`else
        // Without the watchdog a long wait still completes with no error
        v = '{1'b1, 1'b0, 32'h0000_0A00, 32'h0, 14, 32'h0BAD_F00D, 32'h0BAD_F00D};
        applyStimulus(v);
        checkOutput("no_wd_timeout_err", timeout_err, 0);
`endif

        repeat (2) @(negedge clk);
        checkOutput("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
